softmax_frame_arbiter_16: RTL and testbench
===========================================

# softmax_frame_arbiter_16

Frame-level arbiter that shares one softmax core between two AXI4-Stream requesters. It grants the core to one source for a whole vector, round-robin between sources. It holds that grant until the core has emitted the matching result frame, then routes that result to the owning master port. It sits in front of and behind `softmax_top_16`, because the core accepts only one vector in flight at a time.

## Interface
Parameters:
- `data_size`, 16, element width; every stream bus is 2*data_size bits.
- `MAX_LEN`, 255, maximum elements per frame (1..255); matches the core's 8-bit element count.

Ports:
- `axi_clock_i`  in  1  single clock; everything is rising-edge.
- `axi_reset_n_i`  in  1  reset, asynchronous, active-low.
- `s0_axis_valid_i`, `s0_axis_last_i`  in  1  requester 0 stream.
- `s0_axis_data_i`  in  2*data_size  requester 0 data.
- `s0_axis_ready_o`  out  1  requester 0 ready.
- `s1_axis_*`  same as the four `s0_axis_*` ports, for requester 1.
- `core_s_axis_valid_o`, `core_s_axis_last_o`  out  1  stream to core input.
- `core_s_axis_data_o`  out  2*data_size  data to core input.
- `core_s_axis_ready_i`  in  1  core input ready.
- `core_m_axis_valid_i`, `core_m_axis_last_i`  in  1  core result stream.
- `core_m_axis_data_i`  in  2*data_size  core result data.
- `core_m_axis_ready_o`  out  1  ready to core output.
- `m0_axis_valid_o`, `m0_axis_last_o`  out  1  result stream to requester 0.
- `m0_axis_data_o`  out  2*data_size  result data to requester 0.
- `m0_axis_ready_i`  in  1  requester 0 result ready.
- `m1_axis_*`  same as the four `m0_axis_*` ports, for requester 1.
- `grant_o`  out  1  index of the source currently owning the core.
- `busy_o`  out  1  high in any state other than IDLE.
- `len_err_o`  out  1  sticky: a frame exceeded MAX_LEN.

## Operation
- States:
  - IDLE: no grant, all readies low.
  - FEED: input path connected to the granted source.
  - FLUSH: discard the remainder of an overlong input frame.
  - DRAIN: wait for the core's result frame.
- Registers: `state`, `grant` (1 bit), `prio` (1 bit, the source favoured next), `cnt` (8 bits, elements forwarded), `out_done` (1 bit).
- IDLE arbitration:
  - If exactly one of `s0/s1_axis_valid_i` is high, grant that source.
  - If both are high, grant `prio`.
  - On a grant: set `grant`, clear `cnt` and `out_done`, go to FEED.
  - No input beat is accepted during the IDLE cycle.
- FEED (combinational pass-through for the granted source g):
  - `core_s_axis_valid_o` = `sg_valid`; `sg_ready` = `core_s_axis_ready_i`; data passes through unchanged.
  - The non-granted source's ready is 0.
  - `core_s_axis_last_o` = `sg_last` OR (`cnt` == MAX_LEN-1).
  - On each handshake `cnt` increments.
  - On a handshake with `sg_last`, go to DRAIN.
  - On a handshake with `cnt` == MAX_LEN-1 and `sg_last` low, set `len_err_o` and go to FLUSH.
- FLUSH:
  - `core_s_axis_valid_o` = 0 and `sg_ready` = 1.
  - Beats are discarded until `sg_last` is handshaken.
  - Exit to IDLE if `out_done` is set (or the core last handshakes in the same cycle); otherwise exit to DRAIN.
- Output routing, active in FEED, FLUSH and DRAIN:
  - `mg_valid` = `core_m_axis_valid_i` and `core_m_axis_ready_o` = `mg_ready`; data and last pass through.
  - The other master's valid is 0.
  - In IDLE, `core_m_axis_ready_o` = 0 and both master valids are 0.
  - A core output last handshake sets `out_done`.
- DRAIN → IDLE on the core output last handshake. On every return to IDLE, `prio` = ~`grant`.
- `len_err_o` clears only on reset.

## Timing
- Reset values:
  - state = IDLE; `grant`, `prio`, `cnt`, `out_done` = 0.
  - All `*_ready_o`, `*_valid_o`, `*_last_o` = 0; data outputs = 0.
  - `grant_o` = 0, `busy_o` = 0, `len_err_o` = 0.
- Arbitration latency:
  - The grant registers on the first cycle `valid` is seen in IDLE.
  - The first input handshake can occur the following cycle.
- Input and output paths have zero added latency (combinational), with no buffering.
- Back-to-back frames: at least 1 IDLE cycle between the final output last and the next grant.
- A source's `valid` seen in IDLE is not required to stay high; arbitration re-evaluates each IDLE cycle.
- AXI rule: data, last and valid are stable while valid is high and ready is low (pass-through preserves this).
- Reset asserted mid-frame: immediate return to reset values. The core shares the reset.

## Test plan
- Single frame: s0 sends 4 beats (0x0001..0x0004, last on the 4th) with all readies high. Required: `grant_o`=0; the core sees 4 beats 1 cycle after s0 valid; the result is routed only to m0; `busy_o` drops 1 cycle after the result last.
- Contention: s0 and s1 both valid from reset with `prio`=0. Required: s0 is served first, then s1, then s0 again; `s1_axis_ready_o`=0 throughout s0's frame.
- Backpressure: `m1_axis_ready_i` toggles every cycle during s1's result. Required: no beat is lost or duplicated, and `core_m_axis_ready_o` mirrors `m1_axis_ready_i`.
- Overlong frame with MAX_LEN=4: s0 sends 6 beats. Required: the core receives 4 beats with last on the 4th; beats 5–6 are accepted and discarded; `len_err_o`=1 and remains 1.
- Output before flush ends: core result last arrives while in FLUSH. Required: the transition goes directly to IDLE after the s0 last handshake.
- Reset mid-FEED after 2 beats. Required: all outputs return to their reset values, and a fresh frame afterwards is served normally.

Source files
------------

// File: rtl/softmax_frame_arbiter_16.sv
// Shares one single-vector softmax core between two AXI4-Stream requesters.
// Grants the core per frame, round-robin, and routes the result frame back to its owner.
module softmax_frame_arbiter_16 #(
  parameter int data_size = 16,
  parameter int MAX_LEN   = 255
) (
  input  logic                     axi_clock_i,
  input  logic                     axi_reset_n_i,
  input  logic                     s0_axis_valid_i,
  input  logic                     s0_axis_last_i,
  input  logic [2*data_size-1:0]   s0_axis_data_i,
  output logic                     s0_axis_ready_o,
  input  logic                     s1_axis_valid_i,
  input  logic                     s1_axis_last_i,
  input  logic [2*data_size-1:0]   s1_axis_data_i,
  output logic                     s1_axis_ready_o,
  output logic                     core_s_axis_valid_o,
  output logic                     core_s_axis_last_o,
  output logic [2*data_size-1:0]   core_s_axis_data_o,
  input  logic                     core_s_axis_ready_i,
  input  logic                     core_m_axis_valid_i,
  input  logic                     core_m_axis_last_i,
  input  logic [2*data_size-1:0]   core_m_axis_data_i,
  output logic                     core_m_axis_ready_o,
  output logic                     m0_axis_valid_o,
  output logic                     m0_axis_last_o,
  output logic [2*data_size-1:0]   m0_axis_data_o,
  input  logic                     m0_axis_ready_i,
  output logic                     m1_axis_valid_o,
  output logic                     m1_axis_last_o,
  output logic [2*data_size-1:0]   m1_axis_data_o,
  input  logic                     m1_axis_ready_i,
  output logic                     grant_o,
  output logic                     busy_o,
  output logic                     len_err_o
);

  localparam logic [7:0] CNT_LAST = 8'(MAX_LEN - 1);

  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DRAIN} state_t;

  state_t     state, state_nxt;
  logic       grant, grant_nxt;
  logic       prio, prio_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       out_done, out_done_nxt;
  logic       len_err, len_err_nxt;

  logic                   sg_valid, sg_last, mg_ready;
  logic [2*data_size-1:0] sg_data;
  logic                   routing, in_hs, at_limit, out_last_hs;

  assign sg_valid = grant ? s1_axis_valid_i : s0_axis_valid_i;
  assign sg_last  = grant ? s1_axis_last_i  : s0_axis_last_i;
  assign sg_data  = grant ? s1_axis_data_i  : s0_axis_data_i;
  assign mg_ready = grant ? m1_axis_ready_i : m0_axis_ready_i;

  assign routing     = (state != IDLE);
  assign in_hs       = (state == FEED) && sg_valid && core_s_axis_ready_i;
  assign at_limit    = (cnt == CNT_LAST);
  assign out_last_hs = routing && core_m_axis_valid_i && mg_ready && core_m_axis_last_i;

  always_ff @(posedge axi_clock_i or negedge axi_reset_n_i) begin
    if (!axi_reset_n_i) begin
      state    <= IDLE;
      grant    <= 1'b0;
      prio     <= 1'b0;
      cnt      <= '0;
      out_done <= 1'b0;
      len_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      prio     <= prio_nxt;
      cnt      <= cnt_nxt;
      out_done <= out_done_nxt;
      len_err  <= len_err_nxt;
    end
  end

  // A result can finish before an overlong input is flushed; out_done lets FLUSH skip DRAIN.
  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    prio_nxt     = prio;
    cnt_nxt      = cnt;
    out_done_nxt = out_done | out_last_hs;
    len_err_nxt  = len_err;
    case (state)
      IDLE: begin
        if (s0_axis_valid_i || s1_axis_valid_i) begin
          grant_nxt    = (s0_axis_valid_i && s1_axis_valid_i) ? prio : s1_axis_valid_i;
          cnt_nxt      = '0;
          out_done_nxt = 1'b0;
          state_nxt    = FEED;
        end
      end
      FEED: begin
        if (in_hs) begin
          cnt_nxt = cnt + 8'd1;
          if (sg_last) begin
            state_nxt = DRAIN;
          end else if (at_limit) begin
            len_err_nxt = 1'b1;
            state_nxt   = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (sg_valid && sg_last) begin
          state_nxt = (out_done || out_last_hs) ? IDLE : DRAIN;
        end
      end
      DRAIN: begin
        if (out_done || out_last_hs) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (routing && (state_nxt == IDLE)) begin
      prio_nxt = ~grant;
    end
  end

  always_comb begin
    s0_axis_ready_o     = 1'b0;
    s1_axis_ready_o     = 1'b0;
    core_s_axis_valid_o = 1'b0;
    core_s_axis_last_o  = 1'b0;
    core_s_axis_data_o  = '0;
    core_m_axis_ready_o = 1'b0;
    m0_axis_valid_o     = 1'b0;
    m0_axis_last_o      = 1'b0;
    m0_axis_data_o      = '0;
    m1_axis_valid_o     = 1'b0;
    m1_axis_last_o      = 1'b0;
    m1_axis_data_o      = '0;
    case (state)
      FEED: begin
        core_s_axis_valid_o = sg_valid;
        core_s_axis_last_o  = sg_last | at_limit;
        core_s_axis_data_o  = sg_data;
        if (grant) s1_axis_ready_o = core_s_axis_ready_i;
        else       s0_axis_ready_o = core_s_axis_ready_i;
      end
      FLUSH: begin
        if (grant) s1_axis_ready_o = 1'b1;
        else       s0_axis_ready_o = 1'b1;
      end
      default: ;
    endcase
    if (routing) begin
      core_m_axis_ready_o = mg_ready;
      if (grant) begin
        m1_axis_valid_o = core_m_axis_valid_i;
        m1_axis_last_o  = core_m_axis_last_i;
        m1_axis_data_o  = core_m_axis_data_i;
      end else begin
        m0_axis_valid_o = core_m_axis_valid_i;
        m0_axis_last_o  = core_m_axis_last_i;
        m0_axis_data_o  = core_m_axis_data_i;
      end
    end
  end

  assign grant_o   = grant;
  assign busy_o    = routing;
  assign len_err_o = len_err;

endmodule

// File: tb/tb_softmax_frame_arbiter_16.sv
// Bench for softmax_frame_arbiter_16: a small core model echoes each input frame (+0x100),
// and a scoreboard compares everything reaching the core and both master ports.
module tb_softmax_frame_arbiter_16;

  localparam int ML = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s0_valid, s0_last, s0_ready;
  logic [31:0] s0_data;
  logic        s1_valid, s1_last, s1_ready;
  logic [31:0] s1_data;
  logic        core_s_valid, core_s_last, core_s_ready;
  logic [31:0] core_s_data;
  logic        core_m_valid, core_m_last, core_m_ready;
  logic [31:0] core_m_data;
  logic        m0_valid, m0_last, m0_ready;
  logic [31:0] m0_data;
  logic        m1_valid, m1_last, m1_ready;
  logic [31:0] m1_data;
  logic        grant, busy, len_err;

  logic [32:0] exp_core[$];
  logic [33:0] exp_m[$];
  logic [32:0] pend[$];
  int          core_rd = 0;
  int          m_rd = 0;
  int          total = 0;
  int          bad = 0;
  int          frames_in = 0;
  int          frames_next;
  logic [33:0] m_obs;
  logic [33:0] m_cur;
  int          fw0, fw1;

  softmax_frame_arbiter_16 #(.data_size(16), .MAX_LEN(ML)) dut (
    .axi_clock_i(clk),
    .axi_reset_n_i(rst_n),
    .s0_axis_valid_i(s0_valid),
    .s0_axis_last_i(s0_last),
    .s0_axis_data_i(s0_data),
    .s0_axis_ready_o(s0_ready),
    .s1_axis_valid_i(s1_valid),
    .s1_axis_last_i(s1_last),
    .s1_axis_data_i(s1_data),
    .s1_axis_ready_o(s1_ready),
    .core_s_axis_valid_o(core_s_valid),
    .core_s_axis_last_o(core_s_last),
    .core_s_axis_data_o(core_s_data),
    .core_s_axis_ready_i(core_s_ready),
    .core_m_axis_valid_i(core_m_valid),
    .core_m_axis_last_i(core_m_last),
    .core_m_axis_data_i(core_m_data),
    .core_m_axis_ready_o(core_m_ready),
    .m0_axis_valid_o(m0_valid),
    .m0_axis_last_o(m0_last),
    .m0_axis_data_o(m0_data),
    .m0_axis_ready_i(m0_ready),
    .m1_axis_valid_o(m1_valid),
    .m1_axis_last_o(m1_last),
    .m1_axis_data_o(m1_data),
    .m1_axis_ready_i(m1_ready),
    .grant_o(grant),
    .busy_o(busy),
    .len_err_o(len_err)
  );

  always #5 clk = ~clk;

  // Core model: starts a result frame only once the whole input frame has arrived.
  always_comb begin
    frames_next = frames_in
                + ((core_s_valid && core_s_ready && core_s_last) ? 1 : 0)
                - ((core_m_valid && core_m_ready && core_m_last) ? 1 : 0);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend.delete();
      frames_in    <= 0;
      core_m_valid <= 1'b0;
      core_m_last  <= 1'b0;
      core_m_data  <= '0;
    end else begin
      if (core_m_valid && core_m_ready) void'(pend.pop_front());
      if (core_s_valid && core_s_ready) pend.push_back({core_s_last, core_s_data + 32'h100});
      frames_in <= frames_next;
      if (frames_next > 0) begin
        core_m_valid <= 1'b1;
        core_m_last  <= pend[0][32];
        core_m_data  <= pend[0][31:0];
      end else begin
        core_m_valid <= 1'b0;
        core_m_last  <= 1'b0;
        core_m_data  <= '0;
      end
    end
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_src(input bit src, input logic v, input logic [31:0] d, input logic l);
    if (src) begin
      s1_valid = v; s1_data = d; s1_last = l;
    end else begin
      s0_valid = v; s0_data = d; s0_last = l;
    end
  endtask

  task automatic expect_frame(input bit src, input logic [31:0] base, input int n, input bit last_en);
    logic        lst;
    logic [31:0] d;
    bit          complete;
    complete = last_en || (n >= ML);
    for (int i = 0; i < n && i < ML; i++) begin
      d   = base + 32'(i);
      lst = (last_en && (i == n - 1)) || (i == ML - 1);
      exp_core.push_back({lst, d});
      if (complete) exp_m.push_back({src, lst, d + 32'h100});
    end
  endtask

  task automatic apply_stimulus(input bit src, input int n, input logic [31:0] base,
                                input int gap_at, input int gap_len, input bit last_en,
                                output int first_wait);
    int w;
    bit hs;
    first_wait = 0;
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        drive_src(src, 1'b0, '0, 1'b0);
        repeat (gap_len) @(posedge clk);
        #1;
      end
      drive_src(src, 1'b1, base + 32'(i), last_en && (i == n - 1));
      w  = 0;
      hs = 1'b0;
      while (!hs && w < 300) begin
        @(negedge clk);
        hs = src ? s1_ready : s0_ready;
        if (!hs) w++;
      end
      check_output("src_handshake", hs, 1'b1);
      if (hs) begin
        check_output("grant_owner", grant, src);
        check_output("other_ready", src ? s0_ready : s1_ready, 1'b0);
      end
      if (i == 0) first_wait = w;
      @(posedge clk);
      #1;
    end
    drive_src(src, 1'b0, '0, 1'b0);
  endtask

  task automatic wait_results(input string tag);
    int k;
    k = 0;
    while (m_rd < exp_m.size() && k < 400) begin
      @(posedge clk);
      k++;
    end
    check_output({tag, "_results_done"}, m_rd >= exp_m.size(), 1'b1);
    check_output({tag, "_core_beats_done"}, core_rd, exp_core.size());
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n        = 1'b0;
    s0_valid     = 1'b0; s0_last = 1'b0; s0_data = '0;
    s1_valid     = 1'b0; s1_last = 1'b0; s1_data = '0;
    core_s_ready = 1'b1;
    m0_ready     = 1'b1;
    m1_ready     = 1'b1;

    // Scoreboard monitor: every beat into the core and out of either master is checked.
    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (core_s_valid && core_s_ready) begin
            check_output("core_in_extra", core_rd < exp_core.size(), 1'b1);
            if (core_rd < exp_core.size()) begin
              check_output("core_in_beat", {core_s_last, core_s_data}, exp_core[core_rd]);
              core_rd++;
            end
          end
          if (core_m_valid && (m_rd < exp_m.size())) begin
            m_cur = exp_m[m_rd];
            check_output("route_valid", {m1_valid, m0_valid}, m_cur[33] ? 2'b10 : 2'b01);
            check_output("core_m_ready", core_m_ready, m_cur[33] ? m1_ready : m0_ready);
          end
          if ((m0_valid && m0_ready) || (m1_valid && m1_ready)) begin
            m_obs = (m1_valid && m1_ready) ? {1'b1, m1_last, m1_data} : {1'b0, m0_last, m0_data};
            check_output("m_out_extra", m_rd < exp_m.size(), 1'b1);
            if (m_rd < exp_m.size()) begin
              check_output("m_out_beat", m_obs, exp_m[m_rd]);
              m_rd++;
            end
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    check_output("rst_ctl", {s0_ready, s1_ready, core_s_valid, core_s_last, core_m_ready,
                             m0_valid, m0_last, m1_valid, m1_last, grant, busy, len_err}, '0);
    check_output("rst_data", {core_s_data, m0_data}, '0);
    check_output("rst_data1", m1_data, '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single 4-beat frame from s0; exactly MAX_LEN beats must not flag an error.
    expect_frame(1'b0, 32'h1, 4, 1'b1);
    apply_stimulus(1'b0, 4, 32'h1, -1, 0, 1'b1, fw0);
    check_output("t1_first_wait", fw0, 1);
    wait_results("t1");
    check_output("t1_busy_drop", busy, 1'b0);
    check_output("t1_grant", grant, 1'b0);
    check_output("t1_len_err", len_err, 1'b0);

    // Contention straight from reset: s0, then s1, then s0 again.
    pulse_reset();
    expect_frame(1'b0, 32'h10, 3, 1'b1);
    expect_frame(1'b1, 32'h20, 3, 1'b1);
    expect_frame(1'b0, 32'h30, 2, 1'b1);
    fork
      begin
        apply_stimulus(1'b0, 3, 32'h10, -1, 0, 1'b1, fw0);
        apply_stimulus(1'b0, 2, 32'h30, -1, 0, 1'b1, fw0);
      end
      apply_stimulus(1'b1, 3, 32'h20, -1, 0, 1'b1, fw1);
    join
    wait_results("t2");

    // Result backpressure on m1 while s1 owns the core.
    expect_frame(1'b1, 32'h40, 4, 1'b1);
    fork
      apply_stimulus(1'b1, 4, 32'h40, -1, 0, 1'b1, fw1);
      begin
        int k;
        k = 0;
        while (m_rd < exp_m.size() && k < 300) begin
          @(posedge clk);
          #1;
          m1_ready = ~m1_ready;
          k++;
        end
        m1_ready = 1'b1;
      end
    join
    wait_results("t3");

    // Overlong frame; the result finishes during FLUSH, so the final beat returns straight to IDLE.
    expect_frame(1'b0, 32'h50, 6, 1'b1);
    apply_stimulus(1'b0, 6, 32'h50, 4, 8, 1'b1, fw0);
    check_output("t4_direct_idle", busy, 1'b0);
    check_output("t4_len_err", len_err, 1'b1);
    wait_results("t4");
    repeat (3) @(posedge clk);
    #1;
    check_output("t4_len_err_sticky", len_err, 1'b1);

    // Reset in the middle of a FEED after two beats.
    expect_frame(1'b0, 32'h60, 2, 1'b0);
    apply_stimulus(1'b0, 2, 32'h60, -1, 0, 1'b0, fw0);
    check_output("t5_in_feed", busy, 1'b1);
    check_output("t5_len_err_held", len_err, 1'b1);
    check_output("t5_core_beats", core_rd, exp_core.size());
    rst_n = 1'b0;
    #1;
    check_output("t5_rst_ctl", {s0_ready, s1_ready, core_s_valid, core_s_last, core_m_ready,
                                m0_valid, m0_last, m1_valid, m1_last, grant, busy, len_err}, '0);
    check_output("t5_rst_data", {core_s_data, m0_data}, '0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fresh contention after reset must favour s0 again.
    expect_frame(1'b0, 32'h70, 2, 1'b1);
    expect_frame(1'b1, 32'h80, 2, 1'b1);
    fork
      apply_stimulus(1'b0, 2, 32'h70, -1, 0, 1'b1, fw0);
      apply_stimulus(1'b1, 2, 32'h80, -1, 0, 1'b1, fw1);
    join
    wait_results("t6");
    check_output("t6_first_wait", fw0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
